buffer_arbiter: RTL and testbench
=================================

# buffer_arbiter

Arbitration and sequencing controller that shares one single-port `Buffer` word memory between two requesters, e.g. a conv layer writing feature maps and the next layer reading them. Each requester asks for a burst (base address, length, read or write). The arbiter grants round-robin, drives the Buffer's `wr`/`adr`/`dataIn` one word per cycle and returns per-beat strobes and a completion pulse. It sits directly in front of a `Buffer` instance with matching parameters.

## Interface
- `WORD_SIZE`, 32, data word width; must equal the attached Buffer's.
- `LENGTH_SIZE`, 10, number of Buffer words; must equal the attached Buffer's.
- `ADR_SIZE`, derived = clogb2(`LENGTH_SIZE`), not overridable.
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: single clock, all state updates on posedge.
  - `rst` in 1: synchronous, active-high reset.
- Requester ports, for i = 0,1:
  - `reqI` in 1: burst request, sampled only in IDLE.
  - `rwI` in 1: 1 = write burst, 0 = read burst.
  - `baseI` in ADR_SIZE: start address.
  - `lenI` in ADR_SIZE+1: beat count.
  - `wdataI` in WORD_SIZE: write word; must be valid in every cycle where `ackI`=1.
  - `ackI` out 1: one word transferred to/from the Buffer this cycle.
  - `rdataI` out WORD_SIZE: read word, valid when `ackI`=1 and the burst is a read.
  - `doneI` out 1: one-cycle pulse, burst finished.
- Buffer-side ports:
  - `bufWr` out 1: to Buffer `wr`.
  - `bufAdr` out ADR_SIZE: to Buffer `adr`.
  - `bufDataIn` out WORD_SIZE: to Buffer `dataIn`.
  - `bufDataOut` in WORD_SIZE: from Buffer `dataOut`, combinational read.

## Operation
- States: IDLE, BURST, DONE.
- IDLE:
  - If any `reqI` is high, pick an owner and latch owner, rw, base and effective length.
  - Go to BURST if the effective length is nonzero, otherwise go to DONE.
- Arbitration: round-robin on a `lastOwner` bit.
  - Single request: that requester wins.
  - Both requesting: the requester that is not `lastOwner` wins.
  - `lastOwner` updates at grant. Reset value 1, so requester 0 wins the first tie.
- Effective length:
  - `lenI` > LENGTH_SIZE is clamped to LENGTH_SIZE.
  - `baseI` >= LENGTH_SIZE is illegal and forces length 0.
- BURST, each cycle:
  - `bufAdr` = current address, `bufWr` = latched rw, `ackOwner` = 1.
  - `bufDataIn` = owner's `wdata`, combinational mux.
  - Current address increments and wraps from LENGTH_SIZE-1 to 0. The remaining count decrements.
  - The last beat moves the FSM to DONE.
- DONE: `doneOwner` = 1 for exactly one cycle, then IDLE.
- `rdata0` and `rdata1` both carry `bufDataOut`; meaningful only with the matching `ack`.
- Non-owner outputs stay 0: no `ack`, no `done`.
- Requests are not re-sampled during BURST or DONE.
  - Dropping `req` mid-burst has no effect; the burst runs to completion.
  - A `req` still high in the IDLE cycle after `done` is taken as a new request.

## Timing
- Reset:
  - State IDLE, `lastOwner` = 1.
  - `ack0`/`ack1`/`done0`/`done1`/`bufWr` = 0; `bufAdr` = 0; `bufDataIn` = 0 while no write burst is active.
- Latency: `req` high in IDLE at cycle T → first beat (`ack`) at T+1.
- An N-beat burst occupies T+1..T+N, with `done` at T+N+1 and IDLE at T+N+2.
- A zero-length burst gives `done` at T+1 with no beats.
- Back-to-back: the other requester's pending request is granted in the IDLE cycle after `done`. Arbiter throughput is N+2 cycles per burst.
- `rdata` is combinational from `bufAdr` in the same cycle as `ack`; there is no read pipeline.
- A write commits at the posedge ending the `ack` cycle.
- Reset asserted mid-burst aborts to IDLE on the next edge: no `done`, no further writes, and words already written stay written.

## Structure
- Shared package `buffer_arb_pkg`: state encoding constants (IDLE, BURST, DONE), the clogb2 function, and the RW encoding (READ=0, WRITE=1).
- One sub-module, `buffer_adr_gen`:
  - Loadable address counter with wrap at LENGTH_SIZE-1 plus a remaining-beat down-counter.
  - Outputs: current address and a last-beat flag.
- The FSM, arbitration and muxing live in `buffer_arbiter`.

## Test plan
- Single write then read, LENGTH_SIZE=10: req0 write base=2, len=3, data A,B,C gives `ack0` on 3 cycles at addresses 2,3,4 and `done0` one cycle later. Then req0 read base=2, len=3 returns A,B,C with `ack0`.
- Wrap: write base=8, len=4 hits addresses 8,9,0,1; read back matches.
- Contention: req0 and req1 both high from reset with len=2 each. Requester 0 is served first, requester 1 starts the cycle after `done0`, and the next tie goes to requester 0.
- Boundaries:
  - len=0 gives a `done` pulse only, with no `ack`/`bufWr`.
  - len=15 is clamped to 10 beats.
  - base=12 gives `done` with no beats.
- Reset mid-burst: `rst` during beat 2 of a 5-word write. Only 2 words are written, no `done`, all outputs are at reset values the cycle after, and a fresh request works.

Source files
------------

// File: rtl/buffer_arb_pkg.sv
// -----------------------------------------------------------------------------
// buffer_arb_pkg
// Shared definitions for the buffer arbiter and its address generator:
//   - state_t : arbiter FSM states (IDLE, BURST, DONE)
//   - READ / WRITE : burst direction encoding carried on the rw inputs
//   - clogb2  : address width needed to index a given number of words
// -----------------------------------------------------------------------------
package buffer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Smallest width that can hold the values 0 .. value-1; never below 1 so a
    // one-word buffer still gets a real address bus.
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/buffer_adr_gen.sv
// -----------------------------------------------------------------------------
// buffer_adr_gen
// Burst address sequencer: a loadable address counter that wraps from
// LENGTH_SIZE-1 back to 0, paired with a down-counter of remaining beats.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture load_adr / load_len (start of a burst)
//   load_adr    : first address of the burst
//   load_len    : number of beats in the burst (already clamped by the caller)
//   step        : one beat was issued this cycle; advance address, count down
//   adr         : address of the current beat
//   last        : the current beat is the final one of the burst
// -----------------------------------------------------------------------------
module buffer_adr_gen
    import buffer_arb_pkg::*;
#(
    parameter  int LENGTH_SIZE = 10,
    localparam int ADR_SIZE    = clogb2(LENGTH_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [ADR_SIZE-1:0] load_adr,
    input  logic [ADR_SIZE:0]   load_len,
    input  logic                step,
    output logic [ADR_SIZE-1:0] adr,
    output logic                last
);

    localparam logic [ADR_SIZE-1:0] ADR_MAX = ADR_SIZE'(LENGTH_SIZE - 1);

    logic [ADR_SIZE:0] remaining;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            adr       <= '0;
            remaining <= '0;
        end else if (load) begin
            adr       <= load_adr;
            remaining <= load_len;
        end else if (step) begin
            adr       <= (adr == ADR_MAX) ? '0 : adr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    // step is only issued while at least one beat remains, so remaining never
    // underflows; a count of one means this is the closing beat.
    assign last = (remaining == (ADR_SIZE + 1)'(1));

endmodule

// File: rtl/buffer_arbiter.sv
// -----------------------------------------------------------------------------
// buffer_arbiter
// Shares one single-port Buffer between two burst requesters. Grants are
// round-robin on the last owner; the granted burst is driven onto the Buffer
// one word per cycle, followed by a one-cycle done pulse to its owner.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   reqN                  : burst request (sampled only in IDLE), N = 0,1
//   rwN                   : 1 = write burst, 0 = read burst
//   baseN                 : burst start address
//   lenN                  : burst beat count (clamped to LENGTH_SIZE)
//   wdataN                : write word, valid whenever ackN is high
//   ackN                  : one word moved to/from the Buffer this cycle
//   rdataN                : read word (Buffer dataOut), valid with ackN on reads
//   doneN                 : one-cycle pulse, burst finished
//   bufWr/bufAdr/bufDataIn: Buffer write enable, address, write data
//   bufDataOut            : Buffer combinational read data
// -----------------------------------------------------------------------------
module buffer_arbiter
    import buffer_arb_pkg::*;
#(
    parameter  int WORD_SIZE   = 32,
    parameter  int LENGTH_SIZE = 10,
    localparam int ADR_SIZE    = clogb2(LENGTH_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    // requester 0
    input  logic                 req0,
    input  logic                 rw0,
    input  logic [ADR_SIZE-1:0]  base0,
    input  logic [ADR_SIZE:0]    len0,
    input  logic [WORD_SIZE-1:0] wdata0,
    output logic                 ack0,
    output logic [WORD_SIZE-1:0] rdata0,
    output logic                 done0,
    // requester 1
    input  logic                 req1,
    input  logic                 rw1,
    input  logic [ADR_SIZE-1:0]  base1,
    input  logic [ADR_SIZE:0]    len1,
    input  logic [WORD_SIZE-1:0] wdata1,
    output logic                 ack1,
    output logic [WORD_SIZE-1:0] rdata1,
    output logic                 done1,
    // Buffer side
    output logic                 bufWr,
    output logic [ADR_SIZE-1:0]  bufAdr,
    output logic [WORD_SIZE-1:0] bufDataIn,
    input  logic [WORD_SIZE-1:0] bufDataOut
);

    localparam logic [ADR_SIZE:0] LEN_MAX = (ADR_SIZE + 1)'(LENGTH_SIZE);

    state_t              state;
    state_t              state_next;
    logic                owner;
    logic                rw;
    logic                last_owner;

    logic                grant;
    logic                grant_owner;
    logic                req_rw;
    logic [ADR_SIZE-1:0] req_base;
    logic [ADR_SIZE:0]   req_len;
    logic [ADR_SIZE:0]   eff_len;

    logic                load;
    logic                step;
    logic                last;
    logic [ADR_SIZE-1:0] cur_adr;
    logic                in_burst;
    logic                in_done;

    // Round-robin: a lone requester always wins; on a tie the requester that
    // did not own the previous burst wins.
    always_comb begin
        grant       = req0 | req1;
        grant_owner = (req0 && req1) ? ~last_owner : req1;
    end

    // Burst parameters of the requester that would win this cycle, with the
    // length made safe: an out-of-range base yields an empty burst, and an
    // over-long burst is cut to one full pass over the buffer.
    always_comb begin
        req_rw   = grant_owner ? rw1   : rw0;
        req_base = grant_owner ? base1 : base0;
        req_len  = grant_owner ? len1  : len0;
        if ({1'b0, req_base} >= LEN_MAX) begin
            eff_len = '0;
        end else if (req_len > LEN_MAX) begin
            eff_len = LEN_MAX;
        end else begin
            eff_len = req_len;
        end
    end

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    load       = 1'b1;
                    state_next = (eff_len != '0) ? BURST : DONE;
                end
            end
            BURST: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // last_owner resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            rw         <= READ;
            last_owner <= 1'b1;
        end else begin
            state <= state_next;
            if (load) begin
                owner      <= grant_owner;
                rw         <= req_rw;
                last_owner <= grant_owner;
            end
        end
    end

    buffer_adr_gen #(
        .LENGTH_SIZE (LENGTH_SIZE)
    ) u_adr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_adr (req_base),
        .load_len (eff_len),
        .step     (step),
        .adr      (cur_adr),
        .last     (last)
    );

    assign in_burst = (state == BURST);
    assign in_done  = (state == DONE);

    // Only the owner sees strobes; the other requester's outputs stay low.
    assign ack0  = in_burst & ~owner;
    assign ack1  = in_burst &  owner;
    assign done0 = in_done  & ~owner;
    assign done1 = in_done  &  owner;

    // Address and write data are held at zero outside an active burst so the
    // Buffer bus is quiet between transfers.
    assign bufWr     = in_burst & (rw == WRITE);
    assign bufAdr    = in_burst ? cur_adr : '0;
    assign bufDataIn = bufWr ? (owner ? wdata1 : wdata0) : '0;

    // No read pipeline: both requesters see the Buffer output directly.
    assign rdata0 = bufDataOut;
    assign rdata1 = bufDataOut;

endmodule

// File: tb/tb_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buffer_arbiter
// Bench for buffer_arbiter with a behavioural single-port Buffer attached.
// Directed bursts come from a table of hand-computed records; contention and
// reset-mid-burst are hand-written sequences; a random phase is checked
// against a transaction-level reference (winner rule, clamped beat count,
// modular address walk and a word-array image of the buffer).
// -----------------------------------------------------------------------------
module tb_buffer_arbiter;
    import buffer_arb_pkg::*;

    localparam int W = 32;
    localparam int L = 10;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, rw0, req1, rw1;
    logic [A-1:0] base0, base1;
    logic [A:0]   len0, len1;
    logic [W-1:0] wdata0, wdata1;
    logic         ack0, ack1, done0, done1;
    logic [W-1:0] rdata0, rdata1;
    logic         bufWr;
    logic [A-1:0] bufAdr;
    logic [W-1:0] bufDataIn, bufDataOut;

    always #5 clk = ~clk;

    buffer_arbiter #(
        .WORD_SIZE   (W),
        .LENGTH_SIZE (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .rw0        (rw0),
        .base0      (base0),
        .len0       (len0),
        .wdata0     (wdata0),
        .ack0       (ack0),
        .rdata0     (rdata0),
        .done0      (done0),
        .req1       (req1),
        .rw1        (rw1),
        .base1      (base1),
        .len1       (len1),
        .wdata1     (wdata1),
        .ack1       (ack1),
        .rdata1     (rdata1),
        .done1      (done1),
        .bufWr      (bufWr),
        .bufAdr     (bufAdr),
        .bufDataIn  (bufDataIn),
        .bufDataOut (bufDataOut)
    );

    // Behavioural Buffer: synchronous write, combinational read.
    logic [W-1:0] mem [16];
    always @(posedge clk) if (bufWr) mem[bufAdr] <= bufDataIn;
    assign bufDataOut = mem[bufAdr];

    logic [1:0]   acks, dones;
    assign acks  = {ack1, ack0};
    assign dones = {done1, done0};

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] ref_mem [L];
    logic         m_last;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rd(input logic id);
        return id ? rdata1 : rdata0;
    endfunction

    function automatic logic [W-1:0] wd(input logic id);
        return id ? wdata1 : wdata0;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic req, input logic rw,
                         input logic [A-1:0] base, input logic [A:0] len);
        if (id) begin
            req1 = req; rw1 = rw; base1 = base; len1 = len;
        end else begin
            req0 = req; rw0 = rw; base0 = base; len0 = len;
        end
    endtask

    // One single-requester burst with hand-computed expectations.
    typedef struct {
        logic          id;
        logic          rw;
        logic [A-1:0]  base;
        logic [A:0]    len;
        logic [W-1:0]  seed;      // beat k carries seed+k (written or expected)
        int            beats;
        logic [9:0][A-1:0] adrs;  // adrs[k] = address of beat k
    } row_t;

    task automatic run_row(input string tag, input row_t r);
        drive(r.id, 1'b1, r.rw, r.base, r.len);
        drive(~r.id, 1'b0, READ, '0, '0);
        @(negedge clk);
        check({tag, " idle ack"}, W'(acks), '0);
        check({tag, " idle wr"}, W'(bufWr), '0);
        next_cycle();
        drive(r.id, 1'b0, r.rw, r.base, r.len);
        m_last = r.id;
        for (int k = 0; k < r.beats; k++) begin
            if (r.id) begin wdata1 = r.seed + W'(k); wdata0 = $urandom; end
            else      begin wdata0 = r.seed + W'(k); wdata1 = $urandom; end
            @(negedge clk);
            check($sformatf("%s beat%0d ack", tag, k), W'(acks), r.id ? 32'd2 : 32'd1);
            check($sformatf("%s beat%0d adr", tag, k), W'(bufAdr), W'(r.adrs[k]));
            check($sformatf("%s beat%0d wr", tag, k), W'(bufWr), W'(r.rw));
            if (r.rw == WRITE) begin
                check($sformatf("%s beat%0d wdata", tag, k), bufDataIn, r.seed + W'(k));
                ref_mem[r.adrs[k]] = r.seed + W'(k);
            end else begin
                check($sformatf("%s beat%0d rdata", tag, k), rd(r.id), r.seed + W'(k));
            end
            next_cycle();
        end
        @(negedge clk);
        check({tag, " done"}, W'(dones), r.id ? 32'd2 : 32'd1);
        check({tag, " done ack"}, W'(acks), '0);
        check({tag, " done wr"}, W'(bufWr), '0);
        next_cycle();
    endtask

    typedef struct {
        logic [3:0]   flags;  // {done1, done0, ack1, ack0}
        logic [A-1:0] adr;
    } cyc_t;

    row_t         rows [9];
    cyc_t         tie_seq [13];
    row_t         tmp;
    logic         q0, q1, win, wrw;
    logic [A-1:0] wbase;
    logic [A:0]   wlen;
    int           nb, adr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        //            id    rw     base  len    seed          beats adrs
        rows[0] = '{1'b1, WRITE, 4'd0, 5'd15, 32'hC000_0000, 10, 40'h98_7654_3210};
        rows[1] = '{1'b0, READ,  4'd0, 5'd15, 32'hC000_0000, 10, 40'h98_7654_3210};
        rows[2] = '{1'b0, WRITE, 4'd2, 5'd3,  32'hA000_0000, 3,  40'h432};
        rows[3] = '{1'b0, READ,  4'd2, 5'd3,  32'hA000_0000, 3,  40'h432};
        rows[4] = '{1'b1, WRITE, 4'd8, 5'd4,  32'hB000_0000, 4,  40'h1098};
        rows[5] = '{1'b0, READ,  4'd8, 5'd4,  32'hB000_0000, 4,  40'h1098};
        rows[6] = '{1'b0, WRITE, 4'd5, 5'd0,  32'hDEAD_0000, 0,  40'h0};
        rows[7] = '{1'b1, WRITE, 4'd12, 5'd3, 32'hDEAD_1000, 0,  40'h0};
        rows[8] = '{1'b1, READ,  4'd5, 5'd1,  32'hC000_0005, 1,  40'h5};

        // Both requesting reads of 2 from reset: 0, then 1, then 0 again.
        tie_seq[0]  = '{4'b0000, 4'd0};
        tie_seq[1]  = '{4'b0001, 4'd0};
        tie_seq[2]  = '{4'b0001, 4'd1};
        tie_seq[3]  = '{4'b0100, 4'd0};
        tie_seq[4]  = '{4'b0000, 4'd0};
        tie_seq[5]  = '{4'b0010, 4'd5};
        tie_seq[6]  = '{4'b0010, 4'd6};
        tie_seq[7]  = '{4'b1000, 4'd0};
        tie_seq[8]  = '{4'b0000, 4'd0};
        tie_seq[9]  = '{4'b0001, 4'd0};
        tie_seq[10] = '{4'b0001, 4'd1};
        tie_seq[11] = '{4'b0100, 4'd0};
        tie_seq[12] = '{4'b0000, 4'd0};

        for (int i = 0; i < L; i++) ref_mem[i] = '0;

        // Reset state, with write-looking inputs present.
        rst = 1'b1;
        drive(1'b0, 1'b1, WRITE, 4'd0, 5'd2);
        drive(1'b1, 1'b1, WRITE, 4'd5, 5'd2);
        wdata0 = 32'h1234_5678;
        wdata1 = 32'h8765_4321;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset ack", W'(acks), '0);
        check("reset done", W'(dones), '0);
        check("reset wr", W'(bufWr), '0);
        check("reset adr", W'(bufAdr), '0);
        check("reset wdata", bufDataIn, '0);

        // Contention from reset, reads so the buffer is untouched.
        rw0 = READ;
        rw1 = READ;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 13; c++) begin
            if (c == 9) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(negedge clk);
            check($sformatf("tie c%0d strobes", c), W'({dones, acks}), W'(tie_seq[c].flags));
            if (tie_seq[c].flags[1:0] != 2'b00)
                check($sformatf("tie c%0d adr", c), W'(bufAdr), W'(tie_seq[c].adr));
            next_cycle();
        end
        m_last = 1'b0;

        for (int i = 0; i < 9; i++) run_row($sformatf("row%0d", i), rows[i]);

        // Reset during beat 2 of a 5-word write over known data.
        tmp = '{1'b0, WRITE, 4'd3, 5'd5, 32'h5555_0000, 5, 40'h7_6543};
        run_row("preload", tmp);
        drive(1'b0, 1'b1, WRITE, 4'd3, 5'd5);
        wdata0 = 32'hE000_0000;
        @(negedge clk);
        check("abort idle ack", W'(acks), '0);
        next_cycle();
        req0 = 1'b0;
        @(negedge clk);
        check("abort beat0 ack", W'(ack0), 32'd1);
        next_cycle();
        wdata0 = 32'hE000_0001;
        rst = 1'b1;
        @(negedge clk);
        check("abort beat1 adr", W'(bufAdr), 32'd4);
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("abort post%0d strobes", c), W'({dones, acks}), '0);
            check($sformatf("abort post%0d wr", c), W'(bufWr), '0);
            check($sformatf("abort post%0d adr", c), W'(bufAdr), '0);
            check($sformatf("abort post%0d wdata", c), bufDataIn, '0);
            next_cycle();
        end
        check("abort mem3", mem[3], 32'hE000_0000);
        check("abort mem4", mem[4], 32'hE000_0001);
        check("abort mem5", mem[5], 32'h5555_0002);
        check("abort mem7", mem[7], 32'h5555_0004);
        ref_mem[3] = 32'hE000_0000;
        ref_mem[4] = 32'hE000_0001;
        m_last = 1'b1;
        tmp = '{1'b0, READ, 4'd3, 5'd2, 32'hE000_0000, 2, 40'h43};
        run_row("fresh", tmp);

        // Random bursts against the transaction-level reference.
        for (int r = 0; r < 40; r++) begin
            q0 = 1'($urandom_range(0, 1));
            q1 = 1'($urandom_range(0, 1));
            if (!q0 && !q1) q0 = 1'b1;
            drive(1'b0, q0, 1'($urandom_range(0, 1)), A'($urandom_range(0, 11)),
                  ($urandom_range(0, 7) == 0) ? 5'd31 : (A + 1)'($urandom_range(0, 12)));
            drive(1'b1, q1, 1'($urandom_range(0, 1)), A'($urandom_range(0, 11)),
                  ($urandom_range(0, 7) == 0) ? 5'd31 : (A + 1)'($urandom_range(0, 12)));
            win   = (q0 && q1) ? ~m_last : q1;
            wrw   = win ? rw1 : rw0;
            wbase = win ? base1 : base0;
            wlen  = win ? len1 : len0;
            nb    = (int'(wbase) >= L) ? 0 : ((int'(wlen) > L) ? L : int'(wlen));
            @(negedge clk);
            check($sformatf("rnd%0d idle", r), W'({dones, acks}), '0);
            next_cycle();
            req0 = 1'b0;
            req1 = 1'b0;
            m_last = win;
            for (int k = 0; k < nb; k++) begin
                wdata0 = $urandom;
                wdata1 = $urandom;
                adr = (int'(wbase) + k) % L;
                @(negedge clk);
                check($sformatf("rnd%0d beat%0d ack", r, k), W'(acks), win ? 32'd2 : 32'd1);
                check($sformatf("rnd%0d beat%0d adr", r, k), W'(bufAdr), W'(adr));
                check($sformatf("rnd%0d beat%0d wr", r, k), W'(bufWr), W'(wrw));
                if (wrw == WRITE) begin
                    check($sformatf("rnd%0d beat%0d wdata", r, k), bufDataIn, wd(win));
                    ref_mem[adr] = wd(win);
                end else begin
                    check($sformatf("rnd%0d beat%0d rdata", r, k), rd(win), ref_mem[adr]);
                end
                next_cycle();
            end
            @(negedge clk);
            check($sformatf("rnd%0d done", r), W'({dones, acks}), win ? 32'h8 : 32'h4);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
